decoder_n_scan: RTL and testbench
=================================

// Module: decoder_n_scan
// PURPOSE
//  Parametrised, registered N-to-2^N one-hot decoder with enable and a valid/ready handshake.
//  Adds an auto-scan mode that steps a one-hot select through all outputs at a programmable rate.
//  Used for digit/row select in multiplexed displays and for bus-slave chip-select generation.
//  Next generation of the 2-to-4 decoder: wider, registered, handshaked, with scan mode and an error pulse.
// PARAMETERS
//  N          2   select width; OUTS = 2**N outputs (localparam, not overridable)
//  SCAN_DIV   4   clk cycles per scan step; legal range >= 1 (1 = step every cycle)
//  ACTIVE_LOW 0   1: Y port is inverted (inactive = 1); internal logic is always active-high
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      asynchronous, active-high reset
//  En       in   1      global enable; low forces all outputs inactive
//  Mode     in   1      0 = direct decode, 1 = auto-scan
//  I        in   N      select index (direct mode)
//  in_valid in   1      I is valid
//  in_ready out  1      block accepts I this cycle
//  Y        out  OUTS   one-hot select (polarity set by ACTIVE_LOW)
//  Y_valid  out  1      Y carries a decoded/scan value
//  Y_ready  in   1      downstream consumed Y (direct mode)
//  Idx      out  N      binary index of the currently active Y bit
//  Err      out  1      one-cycle pulse: input dropped (see BEHAVIOUR)
// BEHAVIOUR
//  Reset (async): state=S_OFF; Y=inactive (0, or all-1 if ACTIVE_LOW); Y_valid=0; Idx=0;
//   Err=0; prescaler=0. All outputs are registered except in_ready.
//  FSM, evaluated every cycle; En=0 has priority over Mode:
//   S_OFF:    En=1 & Mode=0 -> S_DIRECT; En=1 & Mode=1 -> S_SCAN
//   S_DIRECT: En=0 -> S_OFF; Mode=1 -> S_SCAN
//   S_SCAN:   En=0 -> S_OFF; Mode=0 -> S_DIRECT
//  Entry actions, applied on the transition clock edge:
//   -> S_OFF:    Y=inactive, Y_valid=0; Idx and prescaler hold (scan resumes from there)
//   -> S_DIRECT: Y=inactive, Y_valid=0
//   -> S_SCAN:   Idx=0, prescaler=0, Y=onehot(0), Y_valid=1.
//                Exception: from S_OFF with a previous scan position, S_SCAN resumes
//                from the held Idx and prescaler.
//  S_DIRECT:
//   - in_ready = !Y_valid | Y_ready (combinational; single output register).
//   - Accept on in_valid & in_ready. Next edge: Y=onehot(I), Idx=I, Y_valid=1.
//     Latency is 1 clk.
//   - Y_ready & !accept -> Y_valid=0; Y keeps its last value.
//   - Back-to-back accepts with Y_ready held high give full throughput.
//  S_SCAN:
//   - in_ready=0; Y_valid=1 throughout.
//   - Prescaler counts 0..SCAN_DIV-1. On the cycle it reaches SCAN_DIV-1 it wraps to 0
//     and Idx increments mod OUTS (OUTS-1 -> 0). Y=onehot(Idx) follows the same edge.
//   - Y_ready is ignored.
//  S_OFF: in_ready=0.
//  Err=1 for one cycle, registered, when in_valid=1 and in_ready=0 while state is
//   S_SCAN or S_OFF (input dropped). Never raised in S_DIRECT; backpressure there is legal.
//  Y has exactly one bit active whenever Y_valid=1. When Y_valid=0, Y is either inactive
//   or holds its last value as defined above; it is never multi-hot.
//  ACTIVE_LOW applies only at the Y port, including the reset value.
//  Width rules: prescaler width = $clog2(SCAN_DIV)+1. Idx wraps naturally at N bits.
//  Mid-operation reset: all state returns to reset values immediately (async);
//   a pending transfer is lost.
// STRUCTURE
//  decoder_defs.vh (shared include): state encodings S_OFF=2'd0, S_DIRECT=2'd1, S_SCAN=2'd2;
//   macro ONEHOT(idx,n).
//  Sub-module decoder_n_onehot #(N): purely combinational binary -> one-hot with enable.
//   Instanced once and reusable elsewhere.
//  Top level holds the FSM, prescaler, Idx register, output register and Err logic.
// TESTING
//  1. rst pulse mid-cycle, N=2, ACTIVE_LOW=0 -> Y=4'b0000, Y_valid=0, Err=0 asynchronously.
//  2. Direct, En=1, Y_ready=1, I=2'd2 with in_valid -> next cycle Y=4'b0100, Idx=2;
//     I=3 stream -> Y=4'b1000.
//  3. Direct, Y_ready=0 after one accept -> in_ready=0, Y holds 4'b0100;
//     Y_ready=1 -> in_ready=1 the same cycle.
//  4. Scan, SCAN_DIV=4, N=2 -> Y steps 0001,0010,0100,1000,0001, each held 4 clks.
//  5. En low during scan at Idx=2 for 3 clks -> Y=0000; En high -> resumes 0100
//     with prescaler preserved.
//  6. Scan, in_valid=1 -> in_ready=0, Err=1 next cycle.
//     N=3, ACTIVE_LOW=1: reset Y=8'hFF; direct I=5 -> Y=8'b11011111.

Source files
------------

// File: rtl/decoder_n_scan_pkg.sv
// Shared types for the one-hot decoder / scanner.
// FSM state encoding and small helpers.
package decoder_n_scan_pkg;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2
  } state_e;

  function automatic int unsigned psc_width(input int unsigned div);
    return $clog2(div) + 1;
  endfunction

endpackage

// File: rtl/decoder_n_scan_onehot.sv
// Combinational binary to one-hot decoder with enable.
// All outputs are zero while i_en is low.
module decoder_n_scan_onehot #(
  parameter int N = 2
) (
  input  logic [N-1:0]    i_idx,
  input  logic            i_en,
  output logic [2**N-1:0] o_y
);

  always_comb begin
    o_y = '0;
    for (int k = 0; k < 2**N; k++) begin
      o_y[k] = i_en && (i_idx == N'(k));
    end
  end

endmodule

// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N decoder with valid/ready direct mode
// and a prescaled auto-scan mode.
module decoder_n_scan
  import decoder_n_scan_pkg::*;
#(
  parameter int N          = 2,
  parameter int SCAN_DIV   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic            i_mode,
  input  logic [N-1:0]    i_sel,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  output logic [2**N-1:0] o_y,
  output logic            o_y_valid,
  input  logic            i_y_ready,
  output logic [N-1:0]    o_idx,
  output logic            o_err
);

  localparam int OUTS = 2**N;
  localparam int PW   = psc_width(SCAN_DIV);
  localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);

  state_e r_state;
  state_e w_nxt_state;

  logic [OUTS-1:0] r_y;
  logic            r_y_valid;
  logic [N-1:0]    r_idx;
  logic [PW-1:0]   r_psc;
  logic            r_pos;
  logic            r_err;

  logic [N-1:0]    w_nxt_idx;
  logic [PW-1:0]   w_nxt_psc;
  logic            w_nxt_pos;
  logic            w_nxt_yv;
  logic            w_ld_y;
  logic            w_clr_y;
  logic            w_in_ready;
  logic            w_accept;
  logic [OUTS-1:0] w_onehot;

  assign w_in_ready = (r_state == S_DIRECT)
                   && (!r_y_valid || i_y_ready);
  assign w_accept   = i_in_valid && w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_OFF;
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    unique case (r_state)
      S_OFF: begin
        if (i_en) w_nxt_state = i_mode ? S_SCAN : S_DIRECT;
      end
      S_DIRECT: begin
        if (!i_en)      w_nxt_state = S_OFF;
        else if (i_mode) w_nxt_state = S_SCAN;
      end
      S_SCAN: begin
        if (!i_en)       w_nxt_state = S_OFF;
        else if (!i_mode) w_nxt_state = S_DIRECT;
      end
      default: w_nxt_state = S_OFF;
    endcase
  end

  // r_pos marks a scan position worth resuming after S_OFF
  always_comb begin
    w_nxt_idx = r_idx;
    w_nxt_psc = r_psc;
    w_nxt_pos = r_pos;
    w_nxt_yv  = r_y_valid;
    w_ld_y    = 1'b0;
    w_clr_y   = 1'b0;
    if (w_nxt_state != r_state) begin
      unique case (w_nxt_state)
        S_SCAN: begin
          w_ld_y    = 1'b1;
          w_nxt_yv  = 1'b1;
          w_nxt_pos = 1'b1;
          if (!(r_state == S_OFF && r_pos)) begin
            w_nxt_idx = '0;
            w_nxt_psc = '0;
          end
        end
        S_DIRECT: begin
          w_clr_y   = 1'b1;
          w_nxt_yv  = 1'b0;
          w_nxt_pos = 1'b0;
        end
        default: begin
          w_clr_y  = 1'b1;
          w_nxt_yv = 1'b0;
        end
      endcase
    end else begin
      unique case (r_state)
        S_DIRECT: begin
          if (w_accept) begin
            w_nxt_idx = i_sel;
            w_ld_y    = 1'b1;
            w_nxt_yv  = 1'b1;
          end else if (i_y_ready) begin
            w_nxt_yv = 1'b0;
          end
        end
        S_SCAN: begin
          w_ld_y   = 1'b1;
          w_nxt_yv = 1'b1;
          if (r_psc == PSC_LAST) begin
            w_nxt_psc = '0;
            w_nxt_idx = r_idx + N'(1);
          end else begin
            w_nxt_psc = r_psc + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  decoder_n_scan_onehot #(.N(N)) u_onehot (
    .i_idx (w_nxt_idx),
    .i_en  (w_ld_y),
    .o_y   (w_onehot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_idx     <= '0;
      r_psc     <= '0;
      r_pos     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_ld_y || w_clr_y) r_y <= w_onehot;
      r_y_valid <= w_nxt_yv;
      r_idx     <= w_nxt_idx;
      r_psc     <= w_nxt_psc;
      r_pos     <= w_nxt_pos;
      r_err     <= i_in_valid && !w_in_ready
                && (r_state != S_DIRECT);
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_y        = ACTIVE_LOW ? ~r_y : r_y;
  assign o_y_valid  = r_y_valid;
  assign o_idx      = r_idx;
  assign o_err      = r_err;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Directed bench for decoder_n_scan: an N=2 active-high instance
// and an N=3 active-low instance with single-cycle scan steps.
module tb_decoder_n_scan;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic       a_en = 0, a_mode = 0, a_vld = 0, a_yr = 0;
  logic [1:0] a_sel = '0;
  logic       a_rdy, a_yv, a_err;
  logic [3:0] a_y;
  logic [1:0] a_idx;

  logic       b_en = 0, b_mode = 0, b_vld = 0, b_yr = 0;
  logic [2:0] b_sel = '0;
  logic       b_rdy, b_yv, b_err;
  logic [7:0] b_y;
  logic [2:0] b_idx;

  decoder_n_scan #(.N(2), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .rst(rst), .i_en(a_en), .i_mode(a_mode),
    .i_sel(a_sel), .i_in_valid(a_vld), .o_in_ready(a_rdy),
    .o_y(a_y), .o_y_valid(a_yv), .i_y_ready(a_yr),
    .o_idx(a_idx), .o_err(a_err)
  );

  decoder_n_scan #(.N(3), .SCAN_DIV(1), .ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst(rst), .i_en(b_en), .i_mode(b_mode),
    .i_sel(b_sel), .i_in_valid(b_vld), .o_in_ready(b_rdy),
    .o_y(b_y), .o_y_valid(b_yv), .i_y_ready(b_yr),
    .o_idx(b_idx), .o_err(b_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0] e4;

  initial begin
    // async reset asserted mid-cycle, no clock edge needed
    #3 rst = 1'b1;
    #1;
    check("rst_y",     32'(a_y),   32'h0);
    check("rst_yv",    32'(a_yv),  32'h0);
    check("rst_err",   32'(a_err), 32'h0);
    check("rst_idx",   32'(a_idx), 32'h0);
    check("rst_b_y",   32'(b_y),   32'hFF);
    #10 rst = 1'b0;
    tick();

    // direct mode
    a_en = 1; a_mode = 0; a_yr = 1;
    tick();
    check("dir_entry_yv", 32'(a_yv), 32'h0);
    a_vld = 1; a_sel = 2'd2;
    #1 check("dir_rdy", 32'(a_rdy), 32'h1);
    tick();
    check("dir_y2",   32'(a_y),   32'h4);
    check("dir_idx2", 32'(a_idx), 32'h2);
    check("dir_yv2",  32'(a_yv),  32'h1);
    a_sel = 2'd3;
    tick();
    check("dir_y3",   32'(a_y),   32'h8);
    a_vld = 0;
    tick();
    check("dir_drain_yv", 32'(a_yv), 32'h0);
    check("dir_hold_y",   32'(a_y),  32'h8);

    // backpressure
    a_vld = 1; a_sel = 2'd2;
    tick();
    check("bp_y",  32'(a_y), 32'h4);
    a_yr = 0; a_sel = 2'd1;
    #1 check("bp_rdy0", 32'(a_rdy), 32'h0);
    tick();
    check("bp_hold_y", 32'(a_y),   32'h4);
    check("bp_yv",     32'(a_yv),  32'h1);
    check("bp_noerr",  32'(a_err), 32'h0);
    a_vld = 0; a_yr = 1;
    #1 check("bp_rdy1", 32'(a_rdy), 32'h1);
    tick();

    // scan: entry from direct starts at index 0
    a_mode = 1;
    tick();
    check("scan_rdy", 32'(a_rdy), 32'h0);
    for (int c = 0; c <= 16; c++) begin
      e4 = 4'b0001 << ((c / 4) % 4);
      check($sformatf("scan_y%0d", c), 32'(a_y), 32'(e4));
      check($sformatf("scan_yv%0d", c), 32'(a_yv), 32'h1);
      if (c < 16) tick();
    end
    // at idx0/psc0: 9 more steps -> idx2, psc1
    tick(9);
    check("pause_pre_y", 32'(a_y), 32'h4);
    a_en = 0;
    tick(3);
    check("off_y",   32'(a_y),   32'h0);
    check("off_yv",  32'(a_yv),  32'h0);
    check("off_idx", 32'(a_idx), 32'h2);
    a_en = 1;
    tick();
    check("resume_y",  32'(a_y),   32'h4);
    check("resume_yv", 32'(a_yv),  32'h1);
    tick(2);
    check("resume_psc_y", 32'(a_y), 32'h4);
    tick();
    check("resume_step_y", 32'(a_y),   32'h8);
    check("resume_idx",    32'(a_idx), 32'h3);

    // dropped input in scan mode
    a_vld = 1;
    #1 check("scan_drop_rdy", 32'(a_rdy), 32'h0);
    tick();
    check("scan_err", 32'(a_err), 32'h1);
    a_vld = 0;
    tick();
    check("scan_err_clr", 32'(a_err), 32'h0);

    // dropped input while off
    a_en = 0;
    tick();
    a_vld = 1;
    tick();
    check("off_err", 32'(a_err), 32'h1);
    a_vld = 0;

    // mid-operation reset, then scan restarts at index 0
    a_en = 1;
    tick(3);
    #1 rst = 1'b1;
    #1;
    check("mrst_y",   32'(a_y),   32'h0);
    check("mrst_yv",  32'(a_yv),  32'h0);
    check("mrst_idx", 32'(a_idx), 32'h0);
    #1 rst = 1'b0;
    tick(2);
    check("mrst_scan_y", 32'(a_y), 32'h1);

    // N=3, active-low, one step per clock
    b_en = 1; b_mode = 0; b_yr = 1;
    tick();
    check("b_dir_y", 32'(b_y), 32'hFF);
    b_vld = 1; b_sel = 3'd5;
    tick();
    check("b_y5",   32'(b_y),   32'hDF);
    check("b_idx5", 32'(b_idx), 32'h5);
    b_vld = 0; b_mode = 1;
    tick();
    check("b_scan0", 32'(b_y), 32'hFE);
    tick();
    check("b_scan1", 32'(b_y), 32'hFD);
    tick();
    check("b_scan2", 32'(b_y), 32'hFB);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
